interval_timer: RTL

- Timing back-end for the traffic-light main controller.
- Holds the three programmable time parameters (base, extended, yellow) and counts down the interval the controller requests.
- Generates its own seconds tick from the system clock.
- Returns a one-cycle expired pulse that advances the controller's state machine.

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/interval_timer_if.sv | 30 +++
 rtl/second_tick_gen.sv | 32 +++
 rtl/interval_timer.sv | 97 +++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light main controller and its
// interval timer: interval/selector codes, widths, default durations and
// the interval-length helper.
package traffic_pkg;

    localparam int TIME_W  = 4;   // programmable duration, seconds
    localparam int COUNT_W = 5;   // countdown width, holds 2 x 15

    localparam int DEF_BASE_S = 6;
    localparam int DEF_EXT_S  = 3;
    localparam int DEF_YEL_S  = 2;

    typedef enum logic [1:0] {
        INT_BASE = 2'b00,
        INT_EXT  = 2'b01,
        INT_YEL  = 2'b10,
        INT_DBL  = 2'b11
    } interval_e;

    // 2'b11 is reserved and has no selector code.
    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10
    } selector_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // Length in seconds of the requested interval; double base is the
    // base value shifted left, which is why the result is one bit wider.
    function automatic logic [COUNT_W-1:0] interval_length(
        input interval_e         code,
        input logic [TIME_W-1:0] t_base,
        input logic [TIME_W-1:0] t_ext,
        input logic [TIME_W-1:0] t_yel
    );
        case (code)
            INT_BASE: return {1'b0, t_base};
            INT_EXT:  return {1'b0, t_ext};
            INT_YEL:  return {1'b0, t_yel};
            default:  return {t_base, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/interval_timer_if.sv
// interval_timer_if
// Bundle between the traffic controller (master) and the interval timer
// (slave).
//   reprogram/time_selector/time_value : parameter write strobe and data
//   start_timer/interval               : countdown request
//   expired/busy/time_left/tick        : countdown status
interface interval_timer_if;
    import traffic_pkg::*;

    logic                 reprogram;
    logic [1:0]           time_selector;
    logic [TIME_W-1:0]    time_value;
    logic                 start_timer;
    logic [1:0]           interval;
    logic                 expired;
    logic                 busy;
    logic [COUNT_W-1:0]   time_left;
    logic                 tick;

    modport master (
        output reprogram, time_selector, time_value, start_timer, interval,
        input  expired, busy, time_left, tick
    );

    modport slave (
        input  reprogram, time_selector, time_value, start_timer, interval,
        output expired, busy, time_left, tick
    );

endinterface

// File: rtl/second_tick_gen.sv
// second_tick_gen
// Divides the system clock into a one-cycle "second" strobe.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous restart of the divider at 0
//   enable     : divider advances only while high
//   tick       : high while enabled and the divider sits at TICK_DIV-1
module second_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= (count_q == LAST) ? '0 : count_q + DIV_W'(1);
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/interval_timer.sv
// interval_timer
// Timing back-end of the traffic-light controller: holds the base,
// extended and yellow durations and counts down the interval requested
// by the controller, one second per divided tick.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of interval_timer_if
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | no countdown; divider held at 0, time_left = 0
// ST_RUN  | counting; time_left drops by 1 on every tick
module interval_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DEF_BASE = DEF_BASE_S,
    parameter int DEF_EXT  = DEF_EXT_S,
    parameter int DEF_YEL  = DEF_YEL_S
) (
    input  logic              clk,
    input  logic              reset,
    interval_timer_if.slave   bus
);

    logic [TIME_W-1:0]  t_base_q, t_ext_q, t_yel_q;
    timer_state_e       state_q, state_d;
    logic [COUNT_W-1:0] time_left_q, time_left_d;
    logic               expired_q, expired_d;
    logic               run;
    logic               tick_w;

    assign run = (state_q == ST_RUN);

    // Parameter writes never touch a running countdown: the length is
    // copied into time_left at start, so only later starts see new values.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_base_q <= TIME_W'(DEF_BASE);
            t_ext_q  <= TIME_W'(DEF_EXT);
            t_yel_q  <= TIME_W'(DEF_YEL);
        end else if (bus.reprogram && (bus.time_value != '0)) begin
            case (bus.time_selector)
                SEL_BASE: t_base_q <= bus.time_value;
                SEL_EXT:  t_ext_q  <= bus.time_value;
                SEL_YEL:  t_yel_q  <= bus.time_value;
                default:  ;
            endcase
        end
    end

    second_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.start_timer || !run),
        .enable (run),
        .tick   (tick_w)
    );

    // A start strobe takes priority over the tick, so a restart on the
    // final tick edge swallows the expired pulse of the aborted interval.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        expired_d   = 1'b0;
        if (bus.start_timer) begin
            state_d     = ST_RUN;
            time_left_d = interval_length(interval_e'(bus.interval),
                                          t_base_q, t_ext_q, t_yel_q);
        end else if (run && tick_w) begin
            time_left_d = time_left_q - COUNT_W'(1);
            if (time_left_q == COUNT_W'(1)) begin
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            time_left_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.expired   = expired_q;
    assign bus.busy      = run;
    assign bus.time_left = time_left_q;
    assign bus.tick      = tick_w;

endmodule
